// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and streams them, neuron 0 first,
// one word per clock onto the shared next-layer input bus.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic                            in_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun
);

  localparam int CntW = $clog2(numNeurons);
  localparam logic [CntW-1:0] LastCnt = CntW'(numNeurons - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                          state_q, state_d;
  logic [numNeurons*dataWidth-1:0] shift_q, shift_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [dataWidth-1:0]            out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic                            overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  // The final shift cycle may reload directly, so a result arriving with the
  // last word streams without a gap; any other mid-stream arrival is dropped.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid_d = 1'b1;
        out_data_d  = shift_q[dataWidth-1:0];
        shift_d     = shift_q >> dataWidth;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          out_last_d = 1'b1;
          cnt_d      = '0;
          if (in_valid) begin
            shift_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else if (in_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;
  // Registered outputs lag the state by one cycle, so busy covers the last word too.
  assign busy      = (state_q == SHIFT) | out_valid_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench for layer_out_serializer: a small 4x16 instance for directed
// scenarios and a default 30x16 instance for full-length streams.
module tb_layer_out_serializer;

  localparam int SN = 4;
  localparam int SW = 16;
  localparam int BN = 30;
  localparam int BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [SN*SW-1:0] s_in_data;
  logic             s_in_valid;
  logic [SW-1:0]    s_out_data;
  logic             s_out_valid, s_out_last, s_busy, s_overrun;

  logic [BN*BW-1:0] b_in_data;
  logic             b_in_valid;
  logic [BW-1:0]    b_out_data;
  logic             b_out_valid, b_out_last, b_busy, b_overrun;

  int checks = 0;
  int errors = 0;

  // Expected words as {last, data}.
  logic [SW:0] s_exp_q[$];
  logic [BW:0] b_exp_q[$];

  localparam logic [SN*SW-1:0] W1 = {16'h1234, 16'h7FFF, 16'h8000, 16'h0001};
  localparam logic [SN*SW-1:0] W2 = {16'hDEAD, 16'hBEEF, 16'hFFFF, 16'h0000};
  localparam logic [SN*SW-1:0] W3 = {16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};

  layer_out_serializer #(.numNeurons(SN), .dataWidth(SW)) dut_small (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_last(s_out_last),
    .busy(s_busy), .overrun(s_overrun)
  );

  layer_out_serializer dut_big (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .busy(b_busy), .overrun(b_overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Drives a one-cycle in_valid pulse, sampled at the next rising edge.
  task automatic applyStimulus(input logic [SN*SW-1:0] data, input bit accept);
    s_in_data  = data;
    s_in_valid = 1'b1;
    if (accept)
      for (int k = 0; k < SN; k++) s_exp_q.push_back({(k == SN - 1), data[k*SW +: SW]});
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_data  = '0;
  endtask

  function automatic logic [BW-1:0] big_word(input int r, input int k);
    logic [BW-1:0] w;
    w = BW'(r * 16'h1357 + k * 16'h0101);
    if (k[0]) w = w ^ 16'h8000;
    return w;
  endfunction

  task automatic applyStimulusBig(input int r);
    for (int k = 0; k < BN; k++) begin
      b_in_data[k*BW +: BW] = big_word(r, k);
      b_exp_q.push_back({(k == BN - 1), big_word(r, k)});
    end
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_data  = '0;
  endtask

  // Monitors sample away from the rising edge and pop one expected word per valid.
  always @(negedge clk) begin
    logic [SW:0] e;
    if (rst) begin
      if (s_out_valid) begin
        checkOutput("s_busy_with_valid", s_busy, 1);
        if (s_exp_q.size() == 0) begin
          checkOutput("s_unexpected_word", s_out_valid, 0);
        end else begin
          e = s_exp_q.pop_front();
          checkOutput("s_data", s_out_data, e[SW-1:0]);
          checkOutput("s_last", s_out_last, e[SW]);
        end
      end else begin
        checkOutput("s_idle_data", s_out_data, 0);
        checkOutput("s_idle_last", s_out_last, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [BW:0] e;
    if (rst && b_out_valid) begin
      if (b_exp_q.size() == 0) begin
        checkOutput("b_unexpected_word", b_out_valid, 0);
      end else begin
        e = b_exp_q.pop_front();
        checkOutput("b_data", b_out_data, e[BW-1:0]);
        checkOutput("b_last", b_out_last, e[BW]);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    b_in_valid = 1'b0;
    b_in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", s_out_valid, 0);
    checkOutput("reset_busy", s_busy, 0);
    checkOutput("reset_last", s_out_last, 0);
    checkOutput("reset_overrun", s_overrun, 0);
    checkOutput("reset_data", s_out_data, 0);
    checkOutput("reset_big_valid", b_out_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single result");
    applyStimulus(W1, 1);
    checkOutput("t1_busy_after_accept", s_busy, 1);
    checkOutput("t1_no_word_yet", s_out_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t1_busy_on_last", s_busy, 1);
    checkOutput("t1_last_flag", s_out_last, 1);
    @(posedge clk);
    #1;
    checkOutput("t1_busy_after", s_busy, 0);
    checkOutput("t1_valid_after", s_out_valid, 0);
    checkOutput("t1_drained", s_exp_q.size(), 0);

    $display("[TB] back-to-back");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(W2, 1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(W3, 1);
    checkOutput("t2_valid_join", s_out_valid, 1);
    for (int i = 0; i < SN; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t2_valid_contig", s_out_valid, 1);
      checkOutput("t2_busy_contig", s_busy, 1);
    end
    @(posedge clk);
    #1;
    checkOutput("t2_valid_end", s_out_valid, 0);
    checkOutput("t2_overrun", s_overrun, 0);
    checkOutput("t2_drained", s_exp_q.size(), 0);

    $display("[TB] overrun");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(W1, 1);
    @(posedge clk);
    #1;
    applyStimulus(W2, 0);
    checkOutput("t3_overrun_set", s_overrun, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t3_overrun_sticky", s_overrun, 1);
    checkOutput("t3_valid_end", s_out_valid, 0);
    checkOutput("t3_drained", s_exp_q.size(), 0);

    $display("[TB] async reset mid-stream");
    applyStimulus(W3, 1);
    @(posedge clk);
    #1;
    checkOutput("t4_valid_before_reset", s_out_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    s_exp_q.delete();
    b_exp_q.delete();
    #1;
    checkOutput("t4_valid_async", s_out_valid, 0);
    checkOutput("t4_busy_async", s_busy, 0);
    checkOutput("t4_last_async", s_out_last, 0);
    checkOutput("t4_data_async", s_out_data, 0);
    checkOutput("t4_overrun_cleared", s_overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_quiet_valid", s_out_valid, 0);
    checkOutput("t4_quiet_busy", s_busy, 0);
    applyStimulus(W1, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t4_restream_drained", s_exp_q.size(), 0);

    $display("[TB] in_valid held three cycles");
    s_in_data  = W2;
    s_in_valid = 1'b1;
    for (int k = 0; k < SN; k++) s_exp_q.push_back({(k == SN - 1), W2[k*SW +: SW]});
    repeat (3) @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    checkOutput("t6_overrun", s_overrun, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6_drained", s_exp_q.size(), 0);
    checkOutput("t6_valid_end", s_out_valid, 0);

    $display("[TB] default-size streams");
    applyStimulusBig(0);
    repeat (34) @(posedge clk);
    #1;
    applyStimulusBig(1);
    repeat (29) @(posedge clk);
    #1;
    applyStimulusBig(2);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("big_drained", b_exp_q.size(), 0);
    checkOutput("big_overrun", b_overrun, 0);
    checkOutput("big_busy_end", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
